// File: rtl/gemm_pkg.sv
// Shared definitions for the GEMM processing elements: mode encodings, FSM states,
// default widths and the saturating/wrapping add used by the MAC datapaths.
package gemm_pkg;

  localparam int unsigned DefDataWidth = 8;
  localparam int unsigned DefAccWidth  = 32;
  // Widest accumulator the shared adder supports; sums are formed one bit wider.
  localparam int unsigned MaxAccWidth  = 64;

  localparam logic PE_MODE_OS = 1'b0;
  localparam logic PE_MODE_WS = 1'b1;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StOsRun = 2'd1,
    StWsRun = 2'd2
  } pe_state_e;

  typedef struct packed {
    logic                   ovf;
    logic [MaxAccWidth-1:0] val;
  } sat_res_t;

  // Fits an exact sum into a signed field of 'width' bits: clamp or keep the low bits.
  function automatic sat_res_t sat_add(input logic signed [MaxAccWidth:0] sum,
                                       input int unsigned width,
                                       input logic saturate);
    logic signed [MaxAccWidth:0] max_v;
    logic signed [MaxAccWidth:0] min_v;
    sat_res_t res;
    max_v   = (65'sd1 <<< (width - 1)) - 65'sd1;
    min_v   = -max_v - 65'sd1;
    res.ovf = (sum > max_v) || (sum < min_v);
    res.val = sum[MaxAccWidth-1:0];
    if (saturate && res.ovf) begin
      res.val = (sum > max_v) ? max_v[MaxAccWidth-1:0] : min_v[MaxAccWidth-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/pe_sat_mac.sv
// Combinational signed multiply-add: addend + (use_prod ? a*b : 0), saturated or
// wrapped to ACC_WIDTH with an overflow indication.
module pe_sat_mac
  import gemm_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned ACC_WIDTH  = DefAccWidth,
  parameter bit          SATURATE   = 1'b1
) (
  input  logic signed [DATA_WIDTH-1:0] a_i,
  input  logic signed [DATA_WIDTH-1:0] b_i,
  input  logic                         use_prod_i,
  input  logic signed [ACC_WIDTH-1:0]  addend_i,
  output logic signed [ACC_WIDTH-1:0]  sum_o,
  output logic                         ovf_o
);

  logic signed [2*DATA_WIDTH-1:0] a_ext;
  logic signed [2*DATA_WIDTH-1:0] b_ext;
  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [MaxAccWidth:0]    prod_wide;
  logic signed [MaxAccWidth:0]    sum_wide;
  sat_res_t                       res;
  logic                           unused_hi;

  always_comb begin
    a_ext     = {{DATA_WIDTH{a_i[DATA_WIDTH-1]}}, a_i};
    b_ext     = {{DATA_WIDTH{b_i[DATA_WIDTH-1]}}, b_i};
    prod      = a_ext * b_ext;
    prod_wide = {{(MaxAccWidth + 1 - 2 * DATA_WIDTH){prod[2*DATA_WIDTH-1]}}, prod};
    sum_wide  = {{(MaxAccWidth + 1 - ACC_WIDTH){addend_i[ACC_WIDTH-1]}}, addend_i};
    if (use_prod_i) begin
      sum_wide = sum_wide + prod_wide;
    end
    res   = sat_add(sum_wide, ACC_WIDTH, SATURATE);
    sum_o = res.val[ACC_WIDTH-1:0];
    ovf_o = res.ovf;
  end

  assign unused_hi = ^res.val[MaxAccWidth-1:ACC_WIDTH];

endmodule

// File: rtl/pe_mac_cfg.sv
// Systolic GEMM PE with output-stationary and weight-stationary dataflows,
// operand forwarding, saturating accumulation and an OS drain chain.
module pe_mac_cfg
  import gemm_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned ACC_WIDTH  = DefAccWidth,
  parameter bit          SATURATE   = 1'b1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         mode,
  input  logic                         start,
  input  logic                         stop,
  input  logic                         clear_acc,
  input  logic                         a_valid_in,
  input  logic signed [DATA_WIDTH-1:0] a_in,
  input  logic signed [DATA_WIDTH-1:0] b_in,
  input  logic                         w_load_in,
  input  logic                         psum_valid_in,
  input  logic signed [ACC_WIDTH-1:0]  psum_in,
  input  logic                         drain_in,
  output logic                         a_valid_out,
  output logic signed [DATA_WIDTH-1:0] a_out,
  output logic signed [DATA_WIDTH-1:0] b_out,
  output logic                         w_load_out,
  output logic                         drain_out,
  output logic                         psum_valid_out,
  output logic signed [ACC_WIDTH-1:0]  psum_out,
  output logic                         ovf_sticky,
  output logic                         busy
);

  pe_state_e                    state_q, state_d;
  logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic signed [ACC_WIDTH-1:0]  psum_q, psum_d;
  logic signed [DATA_WIDTH-1:0] weight_q, weight_d;
  logic signed [DATA_WIDTH-1:0] a_q, b_q;
  logic                         ovf_q, ovf_d;
  logic                         psum_vld_q, psum_vld_d;
  logic                         busy_q, av_q, wl_q, drain_q;

  logic                         ws_run;
  logic signed [DATA_WIDTH-1:0] mac_b;
  logic signed [ACC_WIDTH-1:0]  mac_addend;
  logic signed [ACC_WIDTH-1:0]  mac_sum;
  logic                         mac_ovf;

  // One adder serves both dataflows: WS adds to the incoming psum, OS to the local acc.
  assign ws_run     = (state_q == StWsRun);
  assign mac_b      = ws_run ? weight_q : b_in;
  assign mac_addend = ws_run ? psum_in : acc_q;

  pe_sat_mac #(
    .DATA_WIDTH(DATA_WIDTH),
    .ACC_WIDTH (ACC_WIDTH),
    .SATURATE  (SATURATE)
  ) u_mac (
    .a_i       (a_in),
    .b_i       (mac_b),
    .use_prod_i(a_valid_in),
    .addend_i  (mac_addend),
    .sum_o     (mac_sum),
    .ovf_o     (mac_ovf)
  );

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    weight_d   = weight_q;
    ovf_d      = ovf_q;
    psum_d     = psum_q;
    psum_vld_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = (mode == PE_MODE_WS) ? StWsRun : StOsRun;
        end
      end
      StOsRun: begin
        if (drain_in) begin
          // Local drain owns the chain this cycle; a colliding upstream value is lost.
          psum_d     = mac_sum;
          psum_vld_d = 1'b1;
          acc_d      = '0;
          ovf_d      = ovf_q | mac_ovf | psum_valid_in;
        end else begin
          psum_d     = psum_in;
          psum_vld_d = psum_valid_in;
          if (a_valid_in) begin
            acc_d = mac_sum;
            ovf_d = ovf_q | mac_ovf;
          end
        end
        if (stop) begin
          state_d = StIdle;
        end
      end
      StWsRun: begin
        psum_d     = mac_sum;
        psum_vld_d = psum_valid_in | a_valid_in;
        ovf_d      = ovf_q | mac_ovf;
        if (w_load_in) begin
          weight_d = b_in;
        end
        if (stop) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (clear_acc) begin
      acc_d = '0;
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      acc_q      <= '0;
      psum_q     <= '0;
      weight_q   <= '0;
      ovf_q      <= 1'b0;
      psum_vld_q <= 1'b0;
      busy_q     <= 1'b0;
      av_q       <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      wl_q       <= 1'b0;
      drain_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      psum_q     <= psum_d;
      weight_q   <= weight_d;
      ovf_q      <= ovf_d;
      psum_vld_q <= psum_vld_d;
      busy_q     <= (state_d != StIdle);
      av_q       <= a_valid_in;
      a_q        <= a_in;
      b_q        <= b_in;
      wl_q       <= w_load_in;
      drain_q    <= drain_in;
    end
  end

  assign a_valid_out    = av_q;
  assign a_out          = a_q;
  assign b_out          = b_q;
  assign w_load_out     = wl_q;
  assign drain_out      = drain_q;
  assign psum_valid_out = psum_vld_q;
  assign psum_out       = psum_q;
  assign ovf_sticky     = ovf_q;
  assign busy           = busy_q;

endmodule
